// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory pin loader
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } loader_state_t;

  // Bit positions inside status = {run, loading, overflow, partial}
  localparam int STAT_PARTIAL  = 0;
  localparam int STAT_OVERFLOW = 1;
  localparam int STAT_LOADING  = 2;
  localparam int STAT_RUN      = 3;

  // Positions of the control pins on the bidirectional input bus
  localparam int PIN_STROBE = 0;
  localparam int PIN_LOAD   = 1;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - multi-flop synchronizer with registered-history rise/fall detection
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      hist  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~hist;
  assign fall = ~chain[STAGES-1] & hist;

endmodule

// File: rtl/imem_pin_loader.sv
// rtl/imem_pin_loader.sv - assembles pin bytes into 32-bit words, writes imem, gates CPU reset
// Optional running byte checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_pin_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pin_data,
  input  logic              pin_strobe,
  input  logic              pin_load,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   word_count,
  output logic [3:0]        status,
  output logic [7:0]        checksum
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(1) << ADDR_W;

  loader_state_t     state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_ptr;
  logic [WIDTH-1:0]  shift_reg;
  logic              wr_pend;
  logic              run_q;
  logic              loading_q;
  logic              overflow;
  logic              partial;

  logic strobe_rise;
  logic strobe_fall_unused;
  logic load_rise;
  logic load_fall;

  pin_sync #(.STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pin_strobe),
    .rise     (strobe_rise),
    .fall     (strobe_fall_unused)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pin_load),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  logic       full;
  logic       accept;
  logic       load_enter;
  logic [1:0] idx_next;

  always_comb begin
    full       = (word_count == FULL_COUNT);
    accept     = (state == ST_LOAD) && strobe_rise && !full;
    load_enter = load_rise && ((state == ST_WAIT) || (state == ST_RUN));
    idx_next   = accept ? byte_idx + 2'd1 : byte_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      byte_idx   <= 2'd0;
      word_ptr   <= '0;
      shift_reg  <= '0;
      wr_pend    <= 1'b0;
      run_q      <= 1'b0;
      loading_q  <= 1'b0;
      overflow   <= 1'b0;
      partial    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst_n  <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we  <= 1'b0;
      wr_pend <= 1'b0;

      // A completed word is written one cycle after its last byte, whatever state follows.
      if (wr_pend) begin
        mem_we     <= 1'b1;
        mem_addr   <= word_ptr;
        mem_wdata  <= shift_reg;
        word_count <= word_count + (ADDR_W+1)'(1);
        if (word_ptr != {ADDR_W{1'b1}}) word_ptr <= word_ptr + ADDR_W'(1);
      end

      unique case (state)
        ST_WAIT: begin
          cpu_rst_n <= 1'b0;
        end

        ST_LOAD: begin
          cpu_rst_n <= 1'b0;
          if (accept) begin
            if (byte_idx == 2'd0)
              shift_reg <= {{(WIDTH-BYTE_W){1'b0}}, pin_data};
            else
              shift_reg[BYTE_W*byte_idx +: BYTE_W] <= pin_data;
            byte_idx <= idx_next;
            if (byte_idx == 2'(BYTES_PER_WORD-1)) wr_pend <= 1'b1;
          end else if (strobe_rise) begin
            overflow <= 1'b1;
          end
          // The fall is judged on the byte index after any byte arriving this cycle.
          if (load_fall) begin
            if (idx_next != 2'd0) begin
              state <= ST_FLUSH;
            end else begin
              state     <= ST_RUN;
              run_q     <= 1'b1;
              loading_q <= 1'b0;
            end
          end
        end

        ST_FLUSH: begin
          cpu_rst_n <= 1'b0;
          partial   <= 1'b1;
          if (!full) begin
            mem_we     <= 1'b1;
            mem_addr   <= word_ptr;
            mem_wdata  <= shift_reg;
            word_count <= word_count + (ADDR_W+1)'(1);
            if (word_ptr != {ADDR_W{1'b1}}) word_ptr <= word_ptr + ADDR_W'(1);
          end
          byte_idx  <= 2'd0;
          state     <= ST_RUN;
          run_q     <= 1'b1;
          loading_q <= 1'b0;
        end

        ST_RUN: begin
          cpu_rst_n <= 1'b1;
        end

        default: state <= ST_WAIT;
      endcase

      if (load_enter) begin
        state      <= ST_LOAD;
        cpu_rst_n  <= 1'b0;
        word_ptr   <= '0;
        byte_idx   <= 2'd0;
        word_count <= '0;
        overflow   <= 1'b0;
        run_q      <= 1'b0;
        loading_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_RUN]      = run_q;
    status[STAT_LOADING]  = loading_q;
    status[STAT_OVERFLOW] = overflow;
    status[STAT_PARTIAL]  = partial;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'd0;
    end else if (load_enter) begin
      csum <= 8'd0;
    end else if (accept) begin
      csum <= csum + pin_data;
    end
  end

  assign checksum = csum;
`else
  assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_imem_pin_loader.sv
// tb/tb_imem_pin_loader.sv - scoreboard bench for imem_pin_loader with a byte-list reference model
module tb_imem_pin_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int S     = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    pin_data = 8'd0;
  logic          pin_strobe = 1'b0;
  logic          pin_load = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n;
  logic [AW:0]   word_count;
  logic [3:0]    status;
  logic [7:0]    checksum;

  imem_pin_loader #(.ADDR_W(AW), .WIDTH(32), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_data   (pin_data),
    .pin_strobe (pin_strobe),
    .pin_load   (pin_load),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .word_count (word_count),
    .status     (status),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] m_acc[$];
  int         m_sum;
  bit         m_ovf;
  bit         m_partial;
  bit         m_run;
  int         checks;
  int         errors;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(int w);
    wr_t e;
    e.addr = AW'(w);
    e.data = '0;
    for (int i = 0; i < 4; i++)
      if (4*w + i < m_acc.size()) e.data[8*i +: 8] = m_acc[4*w + i];
    exp_q.push_back(e);
  endtask

  task automatic model_fall();
    if (m_acc.size() % 4 != 0) begin
      push_word(m_acc.size() / 4);
      m_partial = 1'b1;
    end
    m_run = 1'b1;
  endtask

  task automatic end_checks();
    logic [7:0] exp_cs;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_cs = 8'(m_sum);
`else
    exp_cs = 8'd0;
`endif
    chk("cpu_rst_n_run", {31'd0, cpu_rst_n}, 32'd1);
    chk("word_count", {29'd0, word_count}, (m_acc.size() + 3) / 4);
    chk("status_run", {28'd0, status}, {28'd0, 1'b1, 1'b0, m_ovf, m_partial});
    chk("checksum", {24'd0, checksum}, {24'd0, exp_cs});
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic start_load();
    int k;
    pin_load = 1'b1;
    if (m_run) begin
      k = 0;
      for (int i = 1; i <= S + 6; i++) begin
        @(negedge clk);
        if (!cpu_rst_n && k == 0) k = i;
      end
      checks++;
      if (k == 0 || k > S + 2) begin
        errors++;
        $display("FAIL cpu_drop_latency actual=%0d expected<=%0d", k, S + 2);
      end
    end else begin
      tick(S + 6);
    end
    m_acc.delete();
    m_sum = 0;
    m_ovf = 1'b0;
    m_run = 1'b0;
    chk("word_count_cleared", {29'd0, word_count}, 32'd0);
    chk("status_loading", {28'd0, status}, {28'd0, 1'b0, 1'b1, 1'b0, m_partial});
  endtask

  task automatic send_byte(logic [7:0] b, bit with_fall);
    bit wr;
    int k;
    pin_data = b;
    tick(S + 3);
    wr = 1'b0;
    if (m_acc.size() < 4 * DEPTH) begin
      m_acc.push_back(b);
      m_sum += b;
      if (m_acc.size() % 4 == 0) begin
        push_word(m_acc.size() / 4 - 1);
        wr = 1'b1;
      end
    end else begin
      m_ovf = 1'b1;
    end
    if (with_fall) model_fall();
    pin_strobe = 1'b1;
    if (with_fall) pin_load = 1'b0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_we && k == 0) k = i;
    end
    if (wr) chk("write_latency", k, S + 2);
    pin_strobe = 1'b0;
    tick($urandom_range(1, 3));
    if (with_fall) begin
      tick(S + 6);
      end_checks();
    end
  endtask

  task automatic end_load();
    model_fall();
    pin_load = 1'b0;
    tick(S + 8);
    end_checks();
  endtask

  // Monitor: every write the DUT presents must match the next expected write.
  initial begin
    wr_t e;
    bit  prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h expected=none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {30'd0, mem_addr}, {30'd0, e.addr});
          chk("write_data", mem_wdata, e.data);
        end
        if (prev_we) begin
          checks++;
          errors++;
          $display("FAIL mem_we_back_to_back actual=1 expected=0");
        end
      end
      prev_we = mem_we;
    end
  end

  initial begin
    logic [7:0] b6[6];
    logic [7:0] b4[4];
    int n;

    m_sum = 0; m_ovf = 0; m_partial = 0; m_run = 0;
    checks = 0; errors = 0;

    tick(5);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(25);
      chk("idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      chk("idle_status", {28'd0, status}, 32'd0);
      chk("idle_word_count", {29'd0, word_count}, 32'd0);
    end

    start_load();
    b4 = '{8'h13, 8'h05, 8'h00, 8'h00};
    foreach (b4[i]) send_byte(b4[i], 1'b0);
    end_load();

    start_load();
    b6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    foreach (b6[i]) send_byte(b6[i], 1'b0);
    end_load();

    start_load();
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 1'b0);
    end_load();

    start_load();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    end_load();

    start_load();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    pin_load = 1'b0;
    rst_n = 1'b0;
    m_acc.delete(); m_sum = 0; m_ovf = 0; m_partial = 0; m_run = 0;
    tick(3);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    tick(S + 4);
    chk("after_reset_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("after_reset_status", {28'd0, status}, 32'd0);
    start_load();
    b4 = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (b4[i]) send_byte(b4[i], 1'b0);
    end_load();

    for (int l = 0; l < 8; l++) begin
      bit fall_now;
      n = $urandom_range(0, 20);
      fall_now = (n > 0) && ($urandom_range(0, 1) == 1);
      start_load();
      for (int i = 0; i < n; i++)
        send_byte(8'($urandom), fall_now && (i == n - 1));
      if (!fall_now) end_load();
    end

    tick(20);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
